// File: rtl/craps_turn_scheduler.sv
// Round-robin turn scheduler sharing one craps engine between NPLAYERS players.
// Forwards the current player's roll, samples the result, keeps scores, forfeits idle turns.
module craps_turn_scheduler #(
    parameter int NPLAYERS   = 4,
    parameter int SCORE_W    = 4,
    parameter int WIN_TARGET = 5,
    parameter int TIMEOUT    = 1000,
    parameter int SETTLE     = 2,
    localparam int IW        = $clog2(NPLAYERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NPLAYERS-1:0]         player_en,
    input  logic [NPLAYERS-1:0]         roll_req,
    input  logic                        eng_win,
    input  logic                        eng_lose,
    output logic                        eng_rb,
    output logic                        eng_clr,
    output logic [IW-1:0]               turn_idx,
    output logic [NPLAYERS-1:0]         turn_oh,
    output logic [NPLAYERS*SCORE_W-1:0] scores,
    output logic                        forfeit,
    output logic                        busy,
    output logic                        game_over,
    output logic [IW-1:0]               winner_idx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ROLL   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_SCORE  = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam int TMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    logic [2:0]                        state, nstate;
    logic [TW-1:0]                     timer, ntimer;
    logic [IW-1:0]                     turn, nturn, win_q, nwin;
    logic [NPLAYERS-1:0][SCORE_W-1:0]  sc, nsc;
    logic                              nforfeit;
    logic                              nbusy;

    // First enabled index after base, wrapping; base = NPLAYERS-1 gives the lowest.
    function automatic logic [IW-1:0] next_en(input logic [NPLAYERS-1:0] en, input int base);
        logic [IW-1:0] r;
        logic          found;
        int            idx;
        r     = '0;
        found = 1'b0;
        for (int k = 1; k <= NPLAYERS; k++) begin
            idx = (base + k) % NPLAYERS;
            if (!found && en[idx]) begin
                r     = IW'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        nstate   = state;
        nturn    = turn;
        ntimer   = timer;
        nsc      = sc;
        nwin     = win_q;
        nforfeit = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start && |player_en) begin
                    nstate = S_CLEAR;
                    nsc    = '0;
                    nwin   = '0;
                    nturn  = next_en(player_en, NPLAYERS - 1);
                end
            end
            S_CLEAR: begin
                nstate = S_WAIT;
                ntimer = TW'(TIMEOUT);
            end
            S_WAIT: begin
                // A roll on the final timer cycle still wins over the forfeit.
                if (roll_req[turn]) begin
                    nstate = S_ROLL;
                end else if (timer == '0) begin
                    nstate   = S_NEXT;
                    nforfeit = 1'b1;
                end else begin
                    ntimer = timer - TW'(1);
                end
            end
            S_ROLL: begin
                nstate = S_SETTLE;
                ntimer = TW'(SETTLE);
            end
            S_SETTLE: begin
                if (timer <= TW'(1)) nstate = S_SCORE;
                else                 ntimer = timer - TW'(1);
            end
            S_SCORE: begin
                if (eng_win) begin
                    nsc[turn] = sc[turn] + SCORE_W'(1);
                    if (sc[turn] == SCORE_W'(WIN_TARGET - 1)) begin
                        nstate = S_DONE;
                        nwin   = turn;
                    end else begin
                        nstate = S_NEXT;
                    end
                end else if (eng_lose) begin
                    nstate = S_NEXT;
                end else begin
                    // Point phase: same player rolls again without clearing the engine.
                    nstate = S_WAIT;
                    ntimer = TW'(TIMEOUT);
                end
            end
            S_NEXT: begin
                if (player_en == '0) begin
                    nstate = S_IDLE;
                    nturn  = '0;
                end else begin
                    nstate = S_CLEAR;
                    nturn  = next_en(player_en, int'(turn));
                end
            end
            default: nstate = S_IDLE;
        endcase
    end

    assign nbusy = (nstate != S_IDLE) && (nstate != S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            turn      <= '0;
            win_q     <= '0;
            sc        <= '0;
            eng_rb    <= 1'b0;
            eng_clr   <= 1'b0;
            forfeit   <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            turn_oh   <= '0;
        end else begin
            state     <= nstate;
            timer     <= ntimer;
            turn      <= nturn;
            win_q     <= nwin;
            sc        <= nsc;
            eng_rb    <= (nstate == S_ROLL);
            eng_clr   <= (nstate == S_CLEAR) || (nstate == S_DONE);
            forfeit   <= nforfeit;
            busy      <= nbusy;
            game_over <= (nstate == S_DONE);
            turn_oh   <= nbusy ? (NPLAYERS'(1) << nturn) : '0;
        end
    end

    assign turn_idx   = turn;
    assign winner_idx = win_q;
    assign scores     = sc;

endmodule

// File: tb/tb_craps_turn_scheduler.sv
// Randomized bench for craps_turn_scheduler against a turn-level model of the game rules.
module tb_craps_turn_scheduler;
    localparam int NP = 4;
    localparam int SW = 4;
    localparam int WT = 2;
    localparam int TO = 8;
    localparam int ST = 2;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              eng_win = 1'b0;
    logic              eng_lose = 1'b0;
    logic [NP-1:0]     player_en = '0;
    logic [NP-1:0]     roll_req = '0;
    logic              eng_rb, eng_clr, forfeit, busy, game_over;
    logic [IW-1:0]     turn_idx, winner_idx;
    logic [NP-1:0]     turn_oh;
    logic [NP*SW-1:0]  scores;

    int n_chk = 0;
    int n_fail = 0;
    int m_turn = 0;
    int m_mode = 0;   // 0 idle, 1 playing (at WAIT_ROLL entry), 2 done
    int m_score[NP];

    craps_turn_scheduler #(
        .NPLAYERS(NP), .SCORE_W(SW), .WIN_TARGET(WT), .TIMEOUT(TO), .SETTLE(ST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .player_en(player_en), .roll_req(roll_req),
        .eng_win(eng_win), .eng_lose(eng_lose), .eng_rb(eng_rb), .eng_clr(eng_clr),
        .turn_idx(turn_idx), .turn_oh(turn_oh), .scores(scores), .forfeit(forfeit),
        .busy(busy), .game_over(game_over), .winner_idx(winner_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP*SW-1:0] m_scores();
        logic [NP*SW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*SW +: SW] = SW'(m_score[i]);
        return r;
    endfunction

    // Lowest enabled index strictly above cur, else lowest overall; cur=-1 gives the lowest.
    function automatic int m_next(input logic [NP-1:0] en, input int cur);
        for (int i = cur + 1; i < NP; i++) if (en[i]) return i;
        for (int i = 0; i <= cur; i++) if (en[i]) return i;
        return cur;
    endfunction

    function automatic logic [NP-1:0] noise();
        logic [NP-1:0] n;
        n = NP'($urandom);
        n[m_turn] = 1'b0;
        return n;
    endfunction

    task automatic chk_turn(input string tag);
        chk({tag, "_idx"}, 32'(turn_idx), m_turn);
        chk({tag, "_oh"}, 32'(turn_oh), 32'(1) << m_turn);
        chk({tag, "_sc"}, 32'(scores), 32'(m_scores()));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rb"}, 32'(eng_rb), 0);
        chk({tag, "_clr"}, 32'(eng_clr), 0);
        chk({tag, "_ff"}, 32'(forfeit), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_over"}, 32'(game_over), 0);
        chk({tag, "_idx"}, 32'(turn_idx), 0);
        chk({tag, "_oh"}, 32'(turn_oh), 0);
        chk({tag, "_win"}, 32'(winner_idx), 0);
        chk({tag, "_sc"}, 32'(scores), 0);
    endtask

    task automatic start_game();
        logic [NP-1:0] en;
        en = ($urandom_range(0, 9) == 0) ? '0 : NP'($urandom);
        player_en = en;
        start = 1'b1;
        step();
        start = 1'b0;
        if (en == '0) begin
            chk("ign_busy", 32'(busy), 0);
            chk("ign_over", 32'(game_over), (m_mode == 2) ? 1 : 0);
        end else begin
            m_mode = 1;
            for (int i = 0; i < NP; i++) m_score[i] = 0;
            m_turn = m_next(en, -1);
            chk("st_clr", 32'(eng_clr), 1);
            chk("st_busy", 32'(busy), 1);
            chk("st_over", 32'(game_over), 0);
            chk_turn("st");
            step();
            chk("st_wait_clr", 32'(eng_clr), 0);
        end
    endtask

    // Called in the NEXT cycle; follows the turn hand-over into CLEAR and WAIT_ROLL.
    task automatic do_next();
        eng_win = 1'b0;
        eng_lose = 1'b0;
        if ($urandom_range(0, 5) == 0) player_en = NP'($urandom);
        step();
        if (player_en == '0) begin
            m_mode = 0;
            chk("nx_idle_busy", 32'(busy), 0);
            chk("nx_idle_oh", 32'(turn_oh), 0);
            chk("nx_idle_sc", 32'(scores), 32'(m_scores()));
        end else begin
            m_turn = m_next(player_en, m_turn);
            chk("nx_clr", 32'(eng_clr), 1);
            chk_turn("nx");
            step();
            chk("nx_wait_clr", 32'(eng_clr), 0);
        end
    endtask

    task automatic play_turn();
        int d;
        int outc;
        if ($urandom_range(0, 9) == 0) begin
            for (int i = 0; i <= TO; i++) begin
                roll_req = noise();
                start = ($urandom_range(0, 7) == 0);
                step();
                chk("to_rb", 32'(eng_rb), 0);
                chk("to_ff", 32'(forfeit), (i == TO) ? 1 : 0);
            end
            roll_req = '0;
            start = 1'b0;
            chk_turn("to");
            do_next();
        end else begin
            d = $urandom_range(0, TO);
            for (int i = 0; i < d; i++) begin
                roll_req = noise();
                start = ($urandom_range(0, 7) == 0);
                step();
                chk("w_rb", 32'(eng_rb), 0);
                chk("w_ff", 32'(forfeit), 0);
            end
            start = 1'b0;
            roll_req = noise() | (NP'(1) << m_turn);
            step();
            roll_req = '0;
            chk("rb_hi", 32'(eng_rb), 1);
            chk_turn("roll");
            outc = $urandom_range(0, 3);
            eng_win = (outc == 0) || (outc == 3);
            eng_lose = (outc == 1) || (outc == 3);
            for (int i = 0; i <= ST; i++) begin
                roll_req = NP'($urandom);
                step();
                chk("rb_lo", 32'(eng_rb), 0);
            end
            roll_req = '0;
            step();
            if (eng_win) begin
                m_score[m_turn]++;
                if (m_score[m_turn] == WT) begin
                    m_mode = 2;
                    chk("dn_over", 32'(game_over), 1);
                    chk("dn_busy", 32'(busy), 0);
                    chk("dn_win", 32'(winner_idx), m_turn);
                    chk("dn_idx", 32'(turn_idx), m_turn);
                    chk("dn_clr", 32'(eng_clr), 1);
                    chk("dn_oh", 32'(turn_oh), 0);
                    chk("dn_sc", 32'(scores), 32'(m_scores()));
                    eng_win = 1'b0;
                    eng_lose = 1'b0;
                    return;
                end
            end
            if (eng_win || eng_lose) begin
                chk("sc_nx_busy", 32'(busy), 1);
                chk("sc_nx_clr", 32'(eng_clr), 0);
                chk("sc_nx_ff", 32'(forfeit), 0);
                chk("sc_nx_sc", 32'(scores), 32'(m_scores()));
                do_next();
            end else begin
                chk("pt_clr", 32'(eng_clr), 0);
                chk("pt_busy", 32'(busy), 1);
                chk("pt_ff", 32'(forfeit), 0);
                chk_turn("pt");
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        #2 rst = 1'b0;
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b1;
        step();

        // Reset dropped while the engine result is settling.
        player_en = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        roll_req = 4'b0001;
        step();
        roll_req = '0;
        chk("mr_rb", 32'(eng_rb), 1);
        step();
        rst = 1'b0;
        #1;
        chk_reset_outputs("mr");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_norb", 32'(eng_rb), 0);
        end
        rst = 1'b1;
        m_mode = 0;
        step();

        repeat (400) begin
            if (m_mode == 1) play_turn();
            else start_game();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/craps_turn_scheduler.md
# craps_turn_scheduler

Round-robin turn scheduler that shares one craps dice-game engine between up to NPLAYERS players. Only the player holding the turn has a roll request forwarded to the engine. The scheduler clears the engine between turns, samples the engine's win/lose result after each roll, and keeps a per-player score. It also forfeits idle turns and declares a game winner. It sits between the debounced player roll buttons and the dice-game engine's Rb and clear inputs.

## Interface
- NPLAYERS, 4: number of player slots (2..8).
- SCORE_W, 4: per-player score width.
- WIN_TARGET, 5: score that ends the game (1..2^SCORE_W-1).
- TIMEOUT, 1000: idle cycles in WAIT_ROLL before a forfeit (1..65535).
- SETTLE, 2: cycles between the eng_rb pulse and sampling eng_win/eng_lose (>=1).

Ports (IW = clog2(NPLAYERS)):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts a new game from IDLE or DONE.
- player_en  in  NPLAYERS  participating players; sampled at start and in NEXT.
- roll_req  in  NPLAYERS  debounced single-cycle roll pulses, one per player.
- eng_win  in  1  engine win level; held until eng_clr.
- eng_lose  in  1  engine lose level; held until eng_clr.
- eng_rb  out  1  one-cycle roll strobe to the engine.
- eng_clr  out  1  one-cycle engine clear; drops the stored point.
- turn_idx  out  IW  index of the current player.
- turn_oh  out  NPLAYERS  one-hot form of turn_idx; all zero in IDLE and DONE.
- scores  out  NPLAYERS*SCORE_W  packed scores; player i is at [i*SCORE_W +: SCORE_W].
- forfeit  out  1  one-cycle pulse when the current player times out.
- busy  out  1  high in every state except IDLE and DONE.
- game_over  out  1  high in DONE.
- winner_idx  out  IW  valid while game_over is high.

## Operation
- FSM states: IDLE, CLEAR, WAIT_ROLL, ROLL, SETTLE, SCORE, NEXT, DONE.
- IDLE: outputs are at reset values.
  - start with player_en != 0: scores are zeroed, turn_idx = lowest enabled index, go to CLEAR.
  - start with player_en == 0: ignored, stay in IDLE.
- CLEAR: eng_clr = 1 for one cycle, then WAIT_ROLL. The idle timer loads TIMEOUT.
- WAIT_ROLL: the timer decrements each cycle.
  - roll_req[turn_idx] = 1: go to ROLL.
  - Timer reaches 0 first: forfeit pulses, go to NEXT. A forfeit counts as a loss (no score change).
  - roll_req bits of other players are ignored in every state.
- ROLL: eng_rb = 1 for one cycle, then SETTLE. The settle counter loads SETTLE.
- SETTLE: counts down SETTLE cycles, then SCORE. Roll requests arriving during ROLL or SETTLE are dropped, not queued.
- SCORE samples the engine result:
  - eng_win: increment the current player's score. If the score now equals WIN_TARGET, go to DONE with winner_idx = turn_idx. Otherwise go to NEXT.
  - eng_lose (and not eng_win): go to NEXT.
  - Both eng_win and eng_lose high: treated as win.
  - Neither high (point phase): go back to WAIT_ROLL with the timer reloaded. The same player keeps the turn and the engine is not cleared.
- NEXT: turn_idx becomes the lowest enabled index strictly above the current one, wrapping past NPLAYERS-1 to 0.
  - If the current player is the only one enabled, the same player keeps the turn.
  - If player_en == 0, go to IDLE with scores held.
  - Otherwise go to CLEAR.
- DONE: eng_clr is held high. Scores, winner_idx and turn_idx are held. start is handled exactly as in IDLE.
- Scores never exceed WIN_TARGET; no wrap is possible.
- rst low from any state: immediate return to IDLE.

## Timing
- Reset values: state IDLE, eng_rb 0, eng_clr 0, forfeit 0, busy 0, game_over 0, turn_idx 0, turn_oh 0, winner_idx 0, scores 0, timers 0.
- All outputs are registered (Moore); no combinational path from input to output.
- start at cycle t: CLEAR (eng_clr) at t+1, WAIT_ROLL at t+2.
- roll_req accepted at cycle r: eng_rb high at r+1, SETTLE covers r+2..r+1+SETTLE, SCORE at r+2+SETTLE.
- SCORE to next player's eng_clr: 2 cycles (NEXT, then CLEAR).
- Timeout: forfeit is asserted in the NEXT cycle, TIMEOUT+1 cycles after WAIT_ROLL is entered.
- If roll_req arrives on the same cycle the timer reaches 0, the roll wins and there is no forfeit.
- start while busy: ignored.

## Test plan
- Reset mid-game: drop rst during SETTLE → next cycle all outputs are at reset values and the engine sees no further eng_rb.
- Basic win: player_en=4'b1111, start, P0 rolls, stub engine asserts eng_win → scores[3:0]=1, turn moves to P1, eng_clr pulses once, eng_rb width is 1 cycle.
- Point phase: P1 rolls, the stub returns neither result twice, then eng_lose → three eng_rb pulses with turn_idx=1 throughout, no score change, turn moves to P2.
- Skip and wrap: player_en=4'b1010 → turn order 1,3,1,3. roll_req[0] and roll_req[2] produce no eng_rb.
- Timeout: player_en=4'b0011, P0 idle with TIMEOUT=8 → forfeit pulses 9 cycles after WAIT_ROLL entry, turn moves to P1, scores unchanged.
- Game end: WIN_TARGET=2, P2 wins twice → game_over=1, winner_idx=2, busy=0, scores[11:8]=2. A further start restarts the game with scores zeroed.
